// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped transmit-only 8N1 console UART with a byte FIFO
// and status/drop-counter registers read back with one cycle of latency.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_AW      = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [29:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  bwe,
    input  logic        ren,
    output logic        hit,
    output logic [31:0] dout,
    output logic        txd
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TONE = TW'(1);
    localparam logic [FIFO_AW:0] PONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0] PFULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q;
    logic [TW-1:0]     tmr_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              txd_q;
    logic [7:0]        mem_q [DEPTH];
    logic [FIFO_AW:0]  wptr_q, rptr_q;
    logic [7:0]        drop_q;
    logic [31:0]       dout_q;
    logic [FIFO_AW:0]  level;
    logic [7:0]        head;
    logic [31:0]       rdata;
    logic              full, busy, bit_end, pop, wr, push_req, push;

    assign hit      = addr[29:2] == BASE_ADDR[31:4];
    assign wr       = hit & (|bwe);
    assign push_req = wr & (addr[1:0] == 2'd0) & bwe[0];
    assign level    = wptr_q - rptr_q;
    assign full     = level == PFULL;
    assign busy     = (state_q != IDLE) | (level != '0);
    assign bit_end  = tmr_q == TMAX;
    // The FIFO is only drained when a frame starts: from IDLE or at the last stop-bit cycle.
    assign pop      = (level != '0) & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
    assign push     = push_req & (~full | pop);
    assign head     = mem_q[rptr_q[FIFO_AW-1:0]];
    assign rdata    = (addr[1:0] == 2'd1) ? {16'b0, 8'(level), 6'b0, busy, full} :
                      (addr[1:0] == 2'd2) ? {24'b0, drop_q} : 32'b0;
    assign dout     = dout_q;
    assign txd      = txd_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            drop_q <= '0;
            dout_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PONE;
            if (pop) rptr_q <= rptr_q + PONE;
            if (wr & (addr[1:0] == 2'd2)) drop_q <= '0;
            else if (push_req & ~push & (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
            if (ren) dout_q <= hit ? rdata : 32'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            tmr_q <= ((state_q == IDLE) | bit_end) ? '0 : tmr_q + TONE;
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    shift_q <= head;
                    txd_q   <= 1'b0;
                end
                START: if (bit_end) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    txd_q   <= shift_q[0];
                    shift_q <= shift_q >> 1;
                end
                DATA: if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                STOP: if (bit_end) begin
                    if (pop) begin
                        state_q <= START;
                        shift_q <= head;
                        txd_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        txd_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus with a read-data scoreboard and a serial
// frame receiver that checks bytes, bit timing and back-to-back framing.
module tb_mmio_uart_tx;
    localparam logic [29:0] BW = 30'h0400_0000;

    typedef struct {
        logic [7:0] d;
        bit         b2b;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  bwe = '0;
    logic        ren = 1'b0;
    logic        hit, txd;
    logic [31:0] dout;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic [31:0] rd_q[$];
    exp_t        tx_q[$];

    mmio_uart_tx #(.BASE_ADDR(32'h1000_0000), .CLKS_PER_BIT(4), .FIFO_AW(3)) dut (
        .clk(clk), .resetn(resetn), .addr(addr), .din(din), .bwe(bwe), .ren(ren),
        .hit(hit), .dout(dout), .txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic bus(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic re, input logic [31:0] exp);
        addr = a;
        din  = d;
        bwe  = be;
        ren  = re;
        if (re) rd_q.push_back(exp);
        @(posedge clk);
        #1;
        bwe = '0;
        ren = 1'b0;
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] exp);
        bus({BW[29:2], off}, 32'h0, 4'h0, 1'b1, exp);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
        bus({BW[29:2], off}, d, be, 1'b0, 32'h0);
    endtask

    task automatic txw(input logic [7:0] d, input logic [3:0] be, input bit acc, input bit b2b);
        exp_t e;
        e.d   = d;
        e.b2b = b2b;
        if (acc) tx_q.push_back(e);
        wr(2'd0, {4{d}}, be);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && tx_q.size() != 0; i++) @(negedge clk);
        chk("drain", tx_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic rp;
    initial begin
        forever begin
            @(posedge clk);
            rp = ren;
            @(negedge clk);
            if (rp) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    $display("FAIL dout unexpected read: got %h required none", dout);
                end else chk("dout", dout, rd_q.pop_front());
            end
        end
    end

    // Serial receiver: samples every falling clock edge, so each bit is seen exactly 4 times.
    int         st, lst;
    logic       ok, ab, smp;
    logic [7:0] fb;
    exp_t       e;
    initial begin
        lst = 0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && txd === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                ab = 1'b0;
                fb = '0;
                smp = 1'b0;
                for (int s = 0; s < 40; s++) begin
                    if (s > 0) @(negedge clk);
                    if (resetn !== 1'b1) begin
                        ab = 1'b1;
                        break;
                    end
                    if (s % 4 == 0) smp = txd;
                    else if (txd !== smp) ok = 1'b0;
                    if (s < 4 && txd !== 1'b0) ok = 1'b0;
                    if (s >= 36 && txd !== 1'b1) ok = 1'b0;
                    if (s >= 4 && s < 36 && s % 4 == 3) fb[s/4-1] = txd;
                end
                if (!ab) begin
                    if (tx_q.size() == 0) begin
                        checks++;
                        $display("FAIL tx unexpected frame: got %h required none", fb);
                    end else begin
                        e = tx_q.pop_front();
                        chk("tx frame", {23'b0, ok, fb}, {23'b0, 1'b1, e.d});
                        if (e.b2b) chk("tx gap", st, lst + 1);
                    end
                    lst = cyc;
                end
            end
        end
    end

    int lows;
    initial begin
        repeat (3) @(negedge clk);
        chk("reset txd", {31'b0, txd}, 1);
        chk("reset dout", dout, 0);
        addr = 30'h0;
        #1 chk("hit outside", {31'b0, hit}, 0);
        addr = {BW[29:2], 2'd1};
        #1 chk("hit inside", {31'b0, hit}, 1);
        @(posedge clk);
        #1 resetn = 1'b1;
        rd(2'd1, 32'h0);

        // Single byte: popped the cycle after the push, start bit the cycle after that.
        txw(8'h55, 4'h1, 1, 0);
        @(negedge clk);
        chk("t1 txd pop cycle", {31'b0, txd}, 1);
        @(negedge clk);
        chk("t1 txd start", {31'b0, txd}, 0);
        rd(2'd1, 32'h0000_0002);
        drain();
        rd(2'd1, 32'h0);

        // Lane masking.
        txw(8'hAB, 4'b0010, 0, 0);
        rd(2'd1, 32'h0);
        txw(8'hAB, 4'hF, 1, 0);
        drain();

        // Fill while busy: eight accepted, the ninth dropped.
        txw(8'h11, 4'h1, 1, 0);
        for (int k = 0; k < 9; k++) txw(8'(8'h21 + k), 4'h1, k < 8, k < 8);
        rd(2'd1, 32'h0000_0803);
        rd(2'd2, 32'h1);
        wr(2'd2, 32'h0, 4'h1);
        rd(2'd2, 32'h0);
        drain();

        // Full FIFO with a push landing on the stop-bit pop: accepted.
        txw(8'hC3, 4'h1, 1, 0);
        for (int k = 1; k <= 8; k++) txw(8'(8'h30 + k), 4'h1, 1, 1);
        repeat (32) @(posedge clk);
        #1;
        txw(8'h99, 4'h1, 1, 1);
        rd(2'd2, 32'h0);
        rd(2'd1, 32'h0000_0803);
        drain();

        // Saturating drop counter: pushes every cycle; only pop cycles (1+40k) accept when full.
        txw(8'hC3, 4'h1, 1, 0);
        for (int i = 1; i <= 340; i++) txw(8'(i), 4'h1, i <= 8 || (i - 1) % 40 == 0, i <= 8 || (i - 1) % 40 == 0);
        rd(2'd2, 32'h0000_00FF);
        repeat (3) begin
            @(negedge clk);
            chk("dout hold", dout, 32'h0000_00FF);
        end
        bus({BW[29:2], 2'd2}, 32'h0, 4'hF, 1'b1, 32'h0000_00FF);
        rd(2'd2, 32'h0);
        rd(2'd1, 32'h0000_0803);
        bus(30'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        rd(2'd0, 32'h0);
        rd(2'd3, 32'h0);
        drain();

        // Reset during data bit 3 with two bytes queued.
        txw(8'h00, 4'h1, 0, 0);
        txw(8'h5A, 4'h1, 0, 0);
        txw(8'hA5, 4'h1, 0, 0);
        rd(2'd1, 32'h0000_0202);
        repeat (15) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("t6 mid-frame txd", {31'b0, txd}, 0);
        @(negedge clk);
        chk("t6 reset txd", {31'b0, txd}, 1);
        chk("t6 reset dout", dout, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        rd(2'd1, 32'h0);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("t6 no frames", lows, 0);
        chk("rd queue empty", rd_q.size(), 0);
        chk("tx queue empty", tx_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
